lsu_avm_pipe_stage: RTL and testbench
=====================================

LSU_AVM_PIPE_STAGE -- requirements
Module: lsu_avm_pipe_stage

Purpose: Avalon-MM pipeline stage placed directly downstream of the wide LSU wrapper's memory port.
- Breaks the interconnect's waitrequest timing path.
- Tracks outstanding read beats and throttles new reads to a bounded capacity.
- Returns responses to the LSU side.

Interface
REQ-001 Parameters (name, default, meaning):
- AWIDTH, 32, address width.
- MWIDTH_BYTES, 32, data bus width in bytes; MWIDTH=8*MWIDTH_BYTES.
- BURSTCOUNT_WIDTH, 6, burstcount width.
- MAX_PENDING, 64, maximum outstanding read beats; must be >= 2^(BURSTCOUNT_WIDTH-1).
- PWIDTH, $clog2(MAX_PENDING+1), pending counter width.

REQ-002 Ports (name, direction, width, meaning). One clock; reset is asynchronous and active-low.
- clock  in  1  sole clock; all state on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- i_avm_address  in  AWIDTH  upstream command address.
- i_avm_read  in  1  upstream read request.
- i_avm_write  in  1  upstream write request.
- i_avm_writedata  in  MWIDTH  upstream write data.
- i_avm_byteenable  in  MWIDTH_BYTES  upstream byte enables.
- i_avm_burstcount  in  BURSTCOUNT_WIDTH  upstream burst length (beats).
- o_avm_waitrequest  out  1  back-pressure to upstream.
- o_avm_readdata  out  MWIDTH  read data to upstream.
- o_avm_readdatavalid  out  1  read data valid to upstream.
- o_avm_writeack  out  1  write acknowledge to upstream.
- avm_address, avm_read, avm_write, avm_writedata, avm_byteenable, avm_burstcount  out  as upstream  downstream command.
- avm_waitrequest  in  1  downstream back-pressure.
- avm_readdata  in  MWIDTH  downstream read data.
- avm_readdatavalid  in  1  downstream read data valid.
- avm_writeack  in  1  downstream write acknowledge.
- o_pending  out  PWIDTH  outstanding read beats.
- o_active  out  1  block busy.
- o_error  out  1  sticky protocol-error flag.

Function
REQ-003 Command path: 2-entry in-order skid buffer (output register OUT, spare register SPARE), each with a valid bit; command = {address, read, write, writedata, byteenable, burstcount}.
REQ-004 Upstream command accepted when (i_avm_read | i_avm_write) & !o_avm_waitrequest; o_avm_waitrequest = SPARE.valid, driven directly from a register.
REQ-005 Accepted command loads OUT if OUT is empty or OUT issues that cycle and SPARE is empty; otherwise it loads SPARE.
REQ-006 When OUT issues and SPARE is valid, SPARE moves to OUT the same cycle.
REQ-007 OUT issues when presented & !avm_waitrequest.
- A write is presented when OUT.valid.
- A read is presented when OUT.valid & (o_pending + OUT.burstcount <= MAX_PENDING).
REQ-008 avm_read/avm_write are forced 0 when the command is not presented; the other command fields always equal OUT's fields.
REQ-009 Commands leave strictly in acceptance order; a throttled read blocks any write behind it.
REQ-010 Each multi-beat write beat is an independent command; beats are never reordered or merged.
REQ-011 Pending counter update, computed at full width without wrap:
- Read issue adds OUT.burstcount.
- avm_readdatavalid subtracts 1.
- Both in the same cycle apply the net sum.
REQ-012 avm_readdatavalid with o_pending==0: counter stays 0 and o_error sets (sticky until reset).
REQ-013 Response path: o_avm_readdata, o_avm_readdatavalid and o_avm_writeack are avm_readdata, avm_readdatavalid and avm_writeack registered by exactly 1 cycle; readdata loads only on valid.
REQ-014 Responses are never back-pressured; no data is dropped.
REQ-015 o_active = OUT.valid | SPARE.valid | (o_pending!=0) | o_avm_readdatavalid | o_avm_writeack.

Reset
REQ-016 On resetn low, asynchronously clear:
- valid bits, o_pending, o_error;
- o_avm_readdatavalid, o_avm_writeack, o_avm_readdata;
- o_avm_waitrequest (0), avm_read, avm_write.
REQ-017 Reset mid-operation discards buffered commands and pending counts; responses arriving after release with o_pending==0 set o_error.
REQ-018 Data registers are also reset to 0; no output is X after reset.

Verification
REQ-019 Single read, burstcount=4, avm_waitrequest=0, four readdatavalid beats -> avm_read one cycle after acceptance; o_pending 4,3,2,1,0; each o_avm_readdatavalid one cycle after its input beat.
REQ-020 avm_waitrequest held 1 for 5 cycles while upstream issues 3 writes (A,B,C) -> o_avm_waitrequest rises after 2 accepted; downstream sees A,B,C in order, none lost or duplicated.
REQ-021 MAX_PENDING=64, two reads of burstcount 32 then a third of 32 with no data returned -> third held (avm_read=0); issues the cycle after o_pending drops to 32.
REQ-022 Read issue of burstcount 8 coincident with readdatavalid at o_pending=3 -> o_pending=10 next cycle.
REQ-023 readdatavalid with o_pending=0 -> o_error=1 and stays 1; resetn pulse -> o_error=0, o_active=0, o_avm_waitrequest=0.
REQ-024 resetn asserted with both skid entries full -> next cycle all valids 0, avm_read=avm_write=0, o_pending=0.

Source files
------------

// File: rtl/lsu_avm_pipe_stage.sv
// Avalon-MM pipeline stage between the wide LSU memory port and the interconnect:
// registered waitrequest via a 2-entry skid buffer, read-beat throttling, 1-cycle response return.
module lsu_avm_pipe_stage #(
  parameter int AWIDTH           = 32,
  parameter int MWIDTH_BYTES     = 32,
  parameter int BURSTCOUNT_WIDTH = 6,
  parameter int MAX_PENDING      = 64,
  parameter int PWIDTH           = $clog2(MAX_PENDING + 1),
  localparam int MWIDTH          = 8 * MWIDTH_BYTES
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [AWIDTH-1:0]           i_avm_address,
  input  logic                        i_avm_read,
  input  logic                        i_avm_write,
  input  logic [MWIDTH-1:0]           i_avm_writedata,
  input  logic [MWIDTH_BYTES-1:0]     i_avm_byteenable,
  input  logic [BURSTCOUNT_WIDTH-1:0] i_avm_burstcount,
  output logic                        o_avm_waitrequest,
  output logic [MWIDTH-1:0]           o_avm_readdata,
  output logic                        o_avm_readdatavalid,
  output logic                        o_avm_writeack,
  output logic [AWIDTH-1:0]           avm_address,
  output logic                        avm_read,
  output logic                        avm_write,
  output logic [MWIDTH-1:0]           avm_writedata,
  output logic [MWIDTH_BYTES-1:0]     avm_byteenable,
  output logic [BURSTCOUNT_WIDTH-1:0] avm_burstcount,
  input  logic                        avm_waitrequest,
  input  logic [MWIDTH-1:0]           avm_readdata,
  input  logic                        avm_readdatavalid,
  input  logic                        avm_writeack,
  output logic [PWIDTH-1:0]           o_pending,
  output logic                        o_active,
  output logic                        o_error
);

  localparam int CMDW = AWIDTH + 2 + MWIDTH + MWIDTH_BYTES + BURSTCOUNT_WIDTH;
  localparam int CW   = ((PWIDTH > BURSTCOUNT_WIDTH) ? PWIDTH : BURSTCOUNT_WIDTH) + 1;

  // Handshake: a command moves upstream->stage when (read|write) & !o_avm_waitrequest,
  // and stage->interconnect when avm_read|avm_write is high & !avm_waitrequest.
  logic [CMDW-1:0]   out_cmd_q, out_cmd_d, spare_cmd_q, spare_cmd_d;
  logic              out_valid_q, out_valid_d, spare_valid_q, spare_valid_d;
  logic [PWIDTH-1:0] pending_q, pending_d;
  logic              error_q, error_d;
  logic              rdv_q, wack_q;
  logic [MWIDTH-1:0] rdata_q;

  logic [CMDW-1:0] in_cmd;
  logic            out_read, out_write;
  logic            accept, read_fits, presented, issue, rd_issue, rdv_ok;

  assign in_cmd = {i_avm_address, i_avm_read, i_avm_write, i_avm_writedata,
                   i_avm_byteenable, i_avm_burstcount};
  assign {avm_address, out_read, out_write, avm_writedata, avm_byteenable, avm_burstcount} = out_cmd_q;

  always_comb begin
    accept    = (i_avm_read | i_avm_write) & ~spare_valid_q;
    // Widened so pending + burstcount cannot wrap before the capacity compare.
    read_fits = (CW'(pending_q) + CW'(out_cmd_q[BURSTCOUNT_WIDTH-1:0])) <= CW'(MAX_PENDING);
    presented = out_valid_q & (~out_read | read_fits);
    issue     = presented & ~avm_waitrequest;
    rd_issue  = issue & out_read;
    rdv_ok    = avm_readdatavalid & (pending_q != '0);
  end

  assign avm_read  = out_read & presented;
  assign avm_write = out_write & presented;

  always_comb begin
    out_cmd_d     = out_cmd_q;
    out_valid_d   = out_valid_q;
    spare_cmd_d   = spare_cmd_q;
    spare_valid_d = spare_valid_q;
    if (issue) begin
      if (spare_valid_q) begin
        out_cmd_d     = spare_cmd_q;
        spare_valid_d = 1'b0;
      end else if (accept) begin
        out_cmd_d = in_cmd;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_cmd_d   = in_cmd;
        out_valid_d = 1'b1;
      end else begin
        spare_cmd_d   = in_cmd;
        spare_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    pending_d = pending_q
              + (rd_issue ? PWIDTH'(out_cmd_q[BURSTCOUNT_WIDTH-1:0]) : '0)
              - (rdv_ok ? PWIDTH'(1) : '0);
    // A beat with nothing outstanding is a protocol violation; the count stays put.
    error_d = error_q | (avm_readdatavalid & (pending_q == '0));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_cmd_q     <= '0;
      out_valid_q   <= 1'b0;
      spare_cmd_q   <= '0;
      spare_valid_q <= 1'b0;
      pending_q     <= '0;
      error_q       <= 1'b0;
      rdv_q         <= 1'b0;
      wack_q        <= 1'b0;
      rdata_q       <= '0;
    end else begin
      out_cmd_q     <= out_cmd_d;
      out_valid_q   <= out_valid_d;
      spare_cmd_q   <= spare_cmd_d;
      spare_valid_q <= spare_valid_d;
      pending_q     <= pending_d;
      error_q       <= error_d;
      rdv_q         <= avm_readdatavalid;
      wack_q        <= avm_writeack;
      if (avm_readdatavalid) rdata_q <= avm_readdata;
    end
  end

  assign o_avm_waitrequest   = spare_valid_q;
  assign o_avm_readdata      = rdata_q;
  assign o_avm_readdatavalid = rdv_q;
  assign o_avm_writeack      = wack_q;
  assign o_pending           = pending_q;
  assign o_error             = error_q;
  assign o_active            = out_valid_q | spare_valid_q | (pending_q != '0) | rdv_q | wack_q;

endmodule

// File: tb/tb_lsu_avm_pipe_stage.sv
// Self-checking bench for lsu_avm_pipe_stage: command-order and response scoreboards
// plus per-scenario tasks for throttling, skid buffering, errors and reset.
module tb_lsu_avm_pipe_stage;

  localparam int AW = 32;
  localparam int MB = 32;
  localparam int MW = 8 * MB;
  localparam int BW = 6;
  localparam int PW = 7;
  localparam int EW = 2 + AW + 32 + BW;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] i_avm_address = '0;
  logic          i_avm_read = 1'b0;
  logic          i_avm_write = 1'b0;
  logic [MW-1:0] i_avm_writedata = '0;
  logic [MB-1:0] i_avm_byteenable = '0;
  logic [BW-1:0] i_avm_burstcount = '0;
  logic          o_avm_waitrequest;
  logic [MW-1:0] o_avm_readdata;
  logic          o_avm_readdatavalid;
  logic          o_avm_writeack;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [MW-1:0] avm_writedata;
  logic [MB-1:0] avm_byteenable;
  logic [BW-1:0] avm_burstcount;
  logic          avm_waitrequest = 1'b0;
  logic [MW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic          avm_writeack = 1'b0;
  logic [PW-1:0] o_pending;
  logic          o_active;
  logic          o_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic [MW-1:0] rsp_q[$];

  lsu_avm_pipe_stage dut (
    .clock(clock), .resetn(resetn),
    .i_avm_address(i_avm_address), .i_avm_read(i_avm_read), .i_avm_write(i_avm_write),
    .i_avm_writedata(i_avm_writedata), .i_avm_byteenable(i_avm_byteenable),
    .i_avm_burstcount(i_avm_burstcount), .o_avm_waitrequest(o_avm_waitrequest),
    .o_avm_readdata(o_avm_readdata), .o_avm_readdatavalid(o_avm_readdatavalid),
    .o_avm_writeack(o_avm_writeack), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_writeack(avm_writeack), .o_pending(o_pending), .o_active(o_active), .o_error(o_error)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic do_reset();
    resetn = 1'b0;
    i_avm_read = 1'b0; i_avm_write = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_writeack = 1'b0;
    #1;
    exp_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  // Drivers: called just after a rising edge, return just after the accepting edge.
  task automatic send_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [BW-1:0] bc);
    int n;
    i_avm_read       = rd;
    i_avm_write      = wr;
    i_avm_address    = addr;
    i_avm_writedata  = {8{addr ^ 32'hA5A5_0000}};
    i_avm_byteenable = '1;
    i_avm_burstcount = bc;
    n = 0;
    @(negedge clock);
    while (o_avm_waitrequest && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (o_avm_waitrequest) begin
      n_checks++; n_fail++;
      $display("FAIL send_cmd_timeout: addr=%h waitrequest still %b, required 0", addr, o_avm_waitrequest);
    end else begin
      exp_q.push_back({rd, wr, addr, addr ^ 32'hA5A5_0000, bc});
    end
    @(posedge clock); #1;
    i_avm_read  = 1'b0;
    i_avm_write = 1'b0;
  endtask

  task automatic beat_on(input logic [31:0] tag);
    avm_readdatavalid = 1'b1;
    avm_readdata      = {8{tag}};
    rsp_q.push_back({8{tag}});
  endtask

  // Scoreboard: downstream command order
  always @(negedge clock) begin
    if (resetn && (avm_read || avm_write) && !avm_waitrequest) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      a = {avm_read, avm_write, avm_address, avm_writedata[31:0], avm_burstcount};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got %h, none expected", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL cmd_order: got %h, expected %h", a, e);
        end
      end
    end
  end

  // Scoreboard: read responses
  always @(negedge clock) begin
    if (resetn && o_avm_readdatavalid) begin
      logic [MW-1:0] e;
      n_checks++;
      if (rsp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got %h", o_avm_readdata[31:0]);
      end else begin
        e = rsp_q.pop_front();
        if (o_avm_readdata !== e) begin
          n_fail++;
          $display("FAIL rsp_data: got %h, expected %h", o_avm_readdata[31:0], e[31:0]);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_checks++;
    if ({o_avm_waitrequest, o_pending, o_error, o_active, avm_read, avm_write,
         o_avm_readdatavalid, o_avm_writeack} !== '0 || o_avm_readdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state: wr=%b pend=%0d err=%b act=%b rd=%b wr=%b rdv=%b wack=%b, all required 0",
               o_avm_waitrequest, o_pending, o_error, o_active, avm_read, avm_write,
               o_avm_readdatavalid, o_avm_writeack);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single_read();
    send_cmd(1'b1, 1'b0, 32'h0000_0100, 6'd4);
    @(negedge clock);
    n_checks++;
    if (avm_read !== 1'b1 || avm_burstcount !== 6'd4 || o_pending !== 7'd0) begin
      n_fail++;
      $display("FAIL single_read_issue: avm_read=%b bc=%0d pend=%0d, required 1 4 0",
               avm_read, avm_burstcount, o_pending);
    end
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      beat_on(32'h1000 + i);
      @(negedge clock);
      n_checks++;
      if (o_pending !== 7'(4 - i) || avm_read !== 1'b0 || o_avm_readdatavalid !== (i > 0)) begin
        n_fail++;
        $display("FAIL single_read_beat%0d: pend=%0d avm_read=%b rdv=%b, required %0d 0 %b",
                 i, o_pending, avm_read, o_avm_readdatavalid, 4 - i, i > 0);
      end
      @(posedge clock); #1;
    end
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_pending !== 7'd0 || o_avm_readdatavalid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_read_last: pend=%0d rdv=%b, required 0 1", o_pending, o_avm_readdatavalid);
    end
    @(negedge clock);
    n_checks++;
    if (o_avm_readdatavalid !== 1'b0 || o_active !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_idle: rdv=%b active=%b, required 0 0", o_avm_readdatavalid, o_active);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_skid_writes();
    avm_waitrequest = 1'b1;
    fork
      begin
        repeat (5) @(posedge clock);
        #1 avm_waitrequest = 1'b0;
      end
    join_none
    send_cmd(1'b0, 1'b1, 32'h0000_0A00, 6'd1);
    send_cmd(1'b0, 1'b1, 32'h0000_0B00, 6'd1);
    @(negedge clock);
    n_checks++;
    if (o_avm_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL skid_full: o_avm_waitrequest=%b, required 1", o_avm_waitrequest);
    end
    @(posedge clock); #1;
    send_cmd(1'b0, 1'b1, 32'h0000_0C00, 6'd1);
    repeat (6) @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0 || o_avm_waitrequest !== 1'b0 || avm_write !== 1'b0) begin
      n_fail++;
      $display("FAIL skid_drain: left=%0d waitreq=%b avm_write=%b, required 0 0 0",
               exp_q.size(), o_avm_waitrequest, avm_write);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_writeack();
    avm_writeack = 1'b1;
    @(posedge clock); #1;
    avm_writeack = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_avm_writeack !== 1'b1 || o_active !== 1'b1) begin
      n_fail++;
      $display("FAIL writeack_fwd: wack=%b active=%b, required 1 1", o_avm_writeack, o_active);
    end
    @(negedge clock);
    n_checks++;
    if (o_avm_writeack !== 1'b0) begin
      n_fail++;
      $display("FAIL writeack_single: wack=%b, required 0", o_avm_writeack);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_throttle();
    send_cmd(1'b1, 1'b0, 32'h0000_2000, 6'd32);
    send_cmd(1'b1, 1'b0, 32'h0000_3000, 6'd32);
    send_cmd(1'b1, 1'b0, 32'h0000_4000, 6'd32);
    @(negedge clock);
    n_checks++;
    if (avm_read !== 1'b0 || o_pending !== 7'd64) begin
      n_fail++;
      $display("FAIL throttle_hold: avm_read=%b pend=%0d, required 0 64", avm_read, o_pending);
    end
    @(posedge clock); #1;
    for (int i = 0; i < 32; i++) begin
      beat_on($urandom_range(32'h0FFF_FFFF, 0));
      @(negedge clock);
      n_checks++;
      if (o_pending !== 7'(64 - i) || avm_read !== 1'b0) begin
        n_fail++;
        $display("FAIL throttle_beat%0d: pend=%0d avm_read=%b, required %0d 0",
                 i, o_pending, avm_read, 64 - i);
      end
      @(posedge clock); #1;
    end
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_pending !== 7'd32 || avm_read !== 1'b1) begin
      n_fail++;
      $display("FAIL throttle_release: pend=%0d avm_read=%b, required 32 1", o_pending, avm_read);
    end
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++;
    if (o_pending !== 7'd64 || avm_read !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_reissue: pend=%0d avm_read=%b, required 64 0", o_pending, avm_read);
    end
    @(posedge clock); #1;
    for (int i = 0; i < 64; i++) begin
      beat_on(32'h5000 + i);
      @(posedge clock); #1;
    end
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_pending !== 7'd0 || o_error !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_drain: pend=%0d err=%b, required 0 0", o_pending, o_error);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_net_update();
    send_cmd(1'b1, 1'b0, 32'h0000_6000, 6'd3);
    @(posedge clock); #1;
    avm_waitrequest = 1'b1;
    send_cmd(1'b1, 1'b0, 32'h0000_7000, 6'd8);
    avm_waitrequest = 1'b0;
    beat_on(32'h7777_0000);
    @(negedge clock);
    n_checks++;
    if (o_pending !== 7'd3 || avm_read !== 1'b1) begin
      n_fail++;
      $display("FAIL net_before: pend=%0d avm_read=%b, required 3 1", o_pending, avm_read);
    end
    @(posedge clock); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_pending !== 7'd10) begin
      n_fail++;
      $display("FAIL net_update: pend=%0d, required 10", o_pending);
    end
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      beat_on(32'h8000 + i);
      @(posedge clock); #1;
    end
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_pending !== 7'd0) begin
      n_fail++;
      $display("FAIL net_drain: pend=%0d, required 0", o_pending);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_error();
    beat_on(32'hDEAD_0001);
    @(posedge clock); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_error !== 1'b1 || o_pending !== 7'd0) begin
      n_fail++;
      $display("FAIL error_set: err=%b pend=%0d, required 1 0", o_error, o_pending);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (o_error !== 1'b1) begin
      n_fail++;
      $display("FAIL error_sticky: err=%b, required 1", o_error);
    end
    @(posedge clock); #1;
    do_reset();
    @(negedge clock);
    n_checks++;
    if (o_error !== 1'b0 || o_active !== 1'b0 || o_avm_waitrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: err=%b active=%b waitreq=%b, required 0 0 0",
               o_error, o_active, o_avm_waitrequest);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_midop();
    send_cmd(1'b1, 1'b0, 32'h0000_9000, 6'd4);
    @(posedge clock); #1;
    avm_waitrequest = 1'b1;
    send_cmd(1'b0, 1'b1, 32'h0000_9A00, 6'd1);
    send_cmd(1'b0, 1'b1, 32'h0000_9B00, 6'd1);
    @(negedge clock);
    n_checks++;
    if (o_avm_waitrequest !== 1'b1 || o_pending !== 7'd4) begin
      n_fail++;
      $display("FAIL midop_full: waitreq=%b pend=%0d, required 1 4", o_avm_waitrequest, o_pending);
    end
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (o_avm_waitrequest !== 1'b0 || avm_read !== 1'b0 || avm_write !== 1'b0 ||
        o_pending !== 7'd0 || o_active !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_async: waitreq=%b rd=%b wr=%b pend=%0d active=%b, required all 0",
               o_avm_waitrequest, avm_read, avm_write, o_pending, o_active);
    end
    do_reset();
    @(negedge clock);
    n_checks++;
    if (avm_write !== 1'b0 || o_pending !== 7'd0 || o_avm_waitrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_after: wr=%b pend=%0d waitreq=%b, required 0 0 0",
               avm_write, o_pending, o_avm_waitrequest);
    end
    @(posedge clock); #1;
    beat_on(32'hBEEF_0002);
    @(posedge clock); #1;
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_error !== 1'b1 || o_pending !== 7'd0) begin
      n_fail++;
      $display("FAIL midop_stale_beat: err=%b pend=%0d, required 1 0", o_error, o_pending);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_skid_writes();
    test_writeack();
    test_throttle();
    test_net_update();
    test_error();
    test_reset_midop();
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0 || rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: cmds=%0d rsps=%0d, required 0 0", exp_q.size(), rsp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
